// File: rtl/cpu_lsu.sv
// RV32I load/store unit: one memory instruction becomes one valid/ready bus transaction.
// Optional misaligned-access trap is enabled by defining CPU_LSU_FAULT_EN.
module cpu_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        fault,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_valid_q, bus_valid_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_wstrb_q, bus_wstrb_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    f3_q, f3_d;

    logic [1:0]    req_size;
    logic [1:0]    req_off;
    logic [3:0]    req_strb;
    logic [31:0]   req_lanes;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_ext;

    assign req_size = req_funct3[1:0];

    // Byte offset after natural-alignment truncation; misaligned halves/words lose low bits.
    always_comb begin
        req_off   = req_addr[1:0];
        req_strb  = 4'b1111;
        req_lanes = req_wdata;
        if (req_size[1]) begin
            req_off = 2'b00;
        end else if (req_size[0]) begin
            req_off   = {req_addr[1], 1'b0};
            req_strb  = 4'b0011 << req_off;
            req_lanes = {2{req_wdata[15:0]}};
        end else begin
            req_strb  = 4'b0001 << req_off;
            req_lanes = {4{req_wdata[7:0]}};
        end
    end

    assign rd_shift = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        rd_ext = bus_rdata;
        if (f3_q[1:0] == 2'b00) begin
            rd_ext = f3_q[2] ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        end else if (f3_q[1:0] == 2'b01) begin
            rd_ext = f3_q[2] ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
        end
    end

`ifdef CPU_LSU_FAULT_EN
    logic fault_q, fault_d;
    logic misaligned;
    assign misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && (req_addr[1:0] != 2'b00));
    assign fault      = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        off_d       = off_q;
        f3_d        = f3_q;
`ifdef CPU_LSU_FAULT_EN
        fault_d     = fault_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bus_addr_d  = {req_addr[31:2], 2'b00};
                    bus_we_d    = req_write;
                    bus_wdata_d = req_lanes;
                    bus_wstrb_d = req_write ? req_strb : 4'b0000;
                    off_d       = req_off;
                    f3_d        = req_funct3;
                    cnt_d       = '0;
                    bus_valid_d = 1'b1;
                    state_d     = BUSY;
`ifdef CPU_LSU_FAULT_EN
                    if (misaligned) begin
                        bus_valid_d = 1'b0;
                        bus_wstrb_d = 4'b0000;
                        rdata_d     = '0;
                        fault_d     = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                if (bus_ready) begin
                    rdata_d     = rd_ext;
                    bus_valid_d = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    state_d     = DONE;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    bus_valid_d = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                err_d   = 1'b0;
`ifdef CPU_LSU_FAULT_EN
                fault_d = 1'b0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            off_q       <= '0;
            f3_q        <= '0;
`ifdef CPU_LSU_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
`ifdef CPU_LSU_FAULT_EN
            fault_q     <= fault_d;
`endif
        end
    end

    // The core holds req_valid during the access and advances at the end of DONE.
    assign stall     = req_valid & (state_q != DONE);
    assign done      = (state_q == DONE);
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
endmodule

// File: doc/cpu_lsu.md
Name: cpu_lsu

Overview:
Load/store unit that consumes the ALU result as the effective address for RV32I loads and stores in the single-cycle core.
- Turns one memory instruction into one transaction on a valid/ready data bus.
- Handles byte-lane steering, write strobes and load sign/zero extension.
- Holds `stall` high so the core freezes the instruction until the access completes.

Parameters:
- `TIMEOUT`, default 255: bus_ready wait limit in cycles before the access is aborted with `err`; 0 disables the watchdog.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: current instruction is a load/store; held stable by the core while `stall`=1.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: access size/sign (RV32I funct3 encoding).
- `req_addr` input 32: effective address (ALU result).
- `req_wdata` input 32: store data (rs2).
- `stall` output 1: core must not advance.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 32: extended load result, valid while `done`=1.
- `err` output 1: bus timeout, valid while `done`=1.
- `fault` output 1: misaligned access, valid while `done`=1 (`CPU_LSU_FAULT_EN` only; otherwise tied 0).
- `bus_valid` output 1: request to memory.
- `bus_we` output 1: write enable.
- `bus_addr` output 32: word-aligned address ({addr[31:2],2'b00}).
- `bus_wdata` output 32: lane-replicated store data.
- `bus_wstrb` output 4: byte write strobes; 0 for loads.
- `bus_ready` input 1: memory accepts/completes the request.
- `bus_rdata` input 32: read word, valid when bus_valid & bus_ready.

Behaviour:
- Reset:
  - state IDLE.
  - bus_valid, bus_we, bus_wstrb, done, err, fault = 0; rdata, bus_addr, bus_wdata = 0; timeout counter = 0.
  - Reset mid-transaction drops bus_valid immediately and discards the access.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if req_valid, latch request, compute lanes, set bus_valid=1 registered, clear the counter, go to BUSY. Exception: a misaligned access with the feature enabled goes directly to DONE with fault=1 and never asserts bus_valid.
  - BUSY: bus_addr, bus_we, bus_wdata and bus_wstrb are held stable. The handshake completes at the edge where bus_valid & bus_ready = 1; then capture the extended read data into rdata, bus_valid=0, go to DONE.
    - Each cycle without bus_ready increments the counter.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no ready: bus_valid=0, err=1, rdata=0, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally. The core advances at the end of this cycle.
- Stall: stall = req_valid & (state != DONE), combinational.
- Minimum load/store latency with bus_ready already high: 3 cycles (IDLE, BUSY, DONE); stall is high for 2 of them.
- Size encoding:
  - Size = funct3[1:0]: 00 byte, 01 half, 1x word.
  - funct3[2] = 1 means zero-extend on loads and is ignored on stores.
- Store lanes:
  - SB: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, wstrb = 0011 << {addr[1],1'b0}.
  - SW: wstrb = 1111.
- Load extract:
  - Shift bus_rdata right by addr[1:0]*8.
  - Take the low byte/half and sign- or zero-extend per funct3[2].
  - Word loads pass through.
- Misaligned definition: half with addr[0]=1, or word with addr[1:0] != 0.
- err and fault are cleared on leaving DONE.

Optional Feature:
Macro `CPU_LSU_FAULT_EN`.
- Defined: misaligned requests are not issued to the bus; the unit goes IDLE->DONE with fault=1, done=1, rdata=0, and wstrb never asserts.
- Undefined: `fault` is tied 0 and misaligned accesses are silently truncated to natural alignment (addr[0] cleared for half, addr[1:0] cleared for word) before lane steering.

Test Plan:
- LW, addr 0x100, bus_rdata 0xDEADBEEF, bus_ready always 1 -> bus_addr 0x100, wstrb 0000, done in cycle 3, rdata 0xDEADBEEF, stall high cycles 1-2 only.
- LB then LBU, addr 0x103, bus_rdata 0x80FF0011 -> rdata 0xFFFFFF80, then 0x00000080.
- SH, addr 0x22, wdata 0x1234ABCD -> bus_addr 0x20, wdata 0xABCDABCD, wstrb 1100, bus_we 1.
- bus_ready held low 4 cycles, then high -> bus_valid and address stable throughout, done 1 cycle after ready, no err.
- TIMEOUT=8, bus_ready never high -> bus_valid drops after 8 BUSY cycles, done=1, err=1, rdata 0. Separately, asserting rst during BUSY clears bus_valid and stall-state in the same cycle.
- LW addr 0x102:
  - With `CPU_LSU_FAULT_EN`: no bus_valid, done+fault next cycle.
  - Without: bus_addr 0x100, fault 0.
